// File: rtl/circuito_uc_balanca.sv
// Control unit for the scale/servo datapath: on a '#' command it evaluates the weight window
// and, if accepted, sweeps the servo gate out and back one step per interval tick.
module circuito_uc_balanca #(
    parameter int MAX_PASSOS = 14,
    parameter int N_PASSOS   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       comando,
    input  logic       pesoMaxIgualZero,
    input  logic       perteceAoIntervalo,
    input  logic       fimContadorIntervalo,
    input  logic       inicioPosicao,
    input  logic       fimPosicao,
    output logic       zeraUpdown,
    output logic       contaUpdown,
    output logic       zeraIntervalo,
    output logic       contaIntervalo,
    output logic       pronto,
    output logic       aceito,
    output logic       rejeitado,
    output logic       nao_configurado,
    output logic       erro,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        AVALIA   = 4'd2,
        REJEITA  = 4'd3,
        NAO_CFG  = 4'd4,
        PASSO    = 4'd5,
        AGUARDA  = 4'd6,
        VERIFICA = 4'd7,
        FIM      = 4'd8,
        ERRO     = 4'd9
    } estado_t;

    localparam logic [N_PASSOS-1:0] MAX_P = N_PASSOS'(MAX_PASSOS);

    estado_t               estado_q, estado_d;
    logic [N_PASSOS-1:0]   passos_q;
    logic                  comando_q;
    logic                  cmd_ev;
    logic [8:0]            saidas_q;

    // fimPosicao carries no sequencing meaning; it is kept only for datapath debug.
    logic unused_fim_posicao;
    assign unused_fim_posicao = fimPosicao;

    assign cmd_ev = comando & ~comando_q;

    // Output vector order: zeraUpdown, contaUpdown, zeraIntervalo, contaIntervalo,
    // pronto, aceito, rejeitado, nao_configurado, erro.
    function automatic logic [8:0] decodifica(input estado_t e);
        case (e)
            INICIAL:  decodifica = 9'b101000000;
            ESPERA:   decodifica = 9'b000010000;
            REJEITA:  decodifica = 9'b000000100;
            NAO_CFG:  decodifica = 9'b000000010;
            PASSO:    decodifica = 9'b011000000;
            AGUARDA:  decodifica = 9'b000100000;
            FIM:      decodifica = 9'b101001000;
            ERRO:     decodifica = 9'b100000001;
            default:  decodifica = 9'b000000000;
        endcase
    endfunction

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:  estado_d = ESPERA;
            ESPERA:   estado_d = cmd_ev ? AVALIA : ESPERA;
            AVALIA: begin
                if (pesoMaxIgualZero)        estado_d = NAO_CFG;
                else if (perteceAoIntervalo) estado_d = PASSO;
                else                         estado_d = REJEITA;
            end
            REJEITA:  estado_d = ESPERA;
            NAO_CFG:  estado_d = ESPERA;
            PASSO:    estado_d = AGUARDA;
            AGUARDA:  estado_d = fimContadorIntervalo ? VERIFICA : AGUARDA;
            // Return to position 0 wins over the watchdog on the last allowed step.
            VERIFICA: begin
                if (inicioPosicao)          estado_d = FIM;
                else if (passos_q == MAX_P) estado_d = ERRO;
                else                        estado_d = PASSO;
            end
            FIM:      estado_d = ESPERA;
            ERRO:     estado_d = ERRO;
            default:  estado_d = INICIAL;
        endcase
    end

    // Outputs are loaded from the decode of the next state so they line up with estado_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= INICIAL;
            passos_q  <= '0;
            comando_q <= 1'b0;
            saidas_q  <= decodifica(INICIAL);
        end else begin
            estado_q  <= estado_d;
            comando_q <= comando;
            saidas_q  <= decodifica(estado_d);
            case (estado_q)
                INICIAL, FIM: passos_q <= '0;
                PASSO:        passos_q <= passos_q + 1'b1;
                default:      passos_q <= passos_q;
            endcase
        end
    end

    assign {zeraUpdown, contaUpdown, zeraIntervalo, contaIntervalo,
            pronto, aceito, rejeitado, nao_configurado, erro} = saidas_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_circuito_uc_balanca.sv
// Directed bench for circuito_uc_balanca: a vector table for single-cycle decisions plus
// hand-written sweep sequences driven by a small position/interval datapath model.
module tb_circuito_uc_balanca;

    logic       clock = 1'b0;
    logic       reset;
    logic       comando, pesoMaxIgualZero, perteceAoIntervalo;
    logic       fimContadorIntervalo, inicioPosicao, fimPosicao;
    logic       zeraUpdown, contaUpdown, zeraIntervalo, contaIntervalo;
    logic       pronto, aceito, rejeitado, nao_configurado, erro;
    logic [3:0] db_estado;
    logic [8:0] act_out;

    int checks = 0;
    int errors = 0;

    // Expected output words: zu cu zi ci pronto aceito rejeitado nao_cfg erro
    localparam logic [8:0] O_INI = 9'b101000000;
    localparam logic [8:0] O_ESP = 9'b000010000;
    localparam logic [8:0] O_NON = 9'b000000000;
    localparam logic [8:0] O_REJ = 9'b000000100;
    localparam logic [8:0] O_NCF = 9'b000000010;
    localparam logic [8:0] O_PAS = 9'b011000000;
    localparam logic [8:0] O_AGU = 9'b000100000;
    localparam logic [8:0] O_FIM = 9'b101001000;
    localparam logic [8:0] O_ERR = 9'b100000001;

    typedef struct packed {
        logic       cmd;
        logic       pmz;
        logic       pert;
        logic       fim;
        logic       ini;
        logic [3:0] est;
        logic [8:0] out;
    } vec_t;

    vec_t vecs[16];

    circuito_uc_balanca #(.MAX_PASSOS(14), .N_PASSOS(4)) dut (
        .clock(clock), .reset(reset), .comando(comando),
        .pesoMaxIgualZero(pesoMaxIgualZero), .perteceAoIntervalo(perteceAoIntervalo),
        .fimContadorIntervalo(fimContadorIntervalo), .inicioPosicao(inicioPosicao),
        .fimPosicao(fimPosicao), .zeraUpdown(zeraUpdown), .contaUpdown(contaUpdown),
        .zeraIntervalo(zeraIntervalo), .contaIntervalo(contaIntervalo), .pronto(pronto),
        .aceito(aceito), .rejeitado(rejeitado), .nao_configurado(nao_configurado),
        .erro(erro), .db_estado(db_estado)
    );

    assign act_out = {zeraUpdown, contaUpdown, zeraIntervalo, contaIntervalo,
                      pronto, aceito, rejeitado, nao_configurado, erro};

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic c, input logic pm, input logic pe, input logic f, input logic i);
        comando = c; pesoMaxIgualZero = pm; perteceAoIntervalo = pe;
        fimContadorIntervalo = f; inicioPosicao = i; fimPosicao = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset_estado", 32'(db_estado), 32'd0);
        check("reset_saidas", 32'(act_out), 32'(O_INI));
        reset = 1'b0;
    endtask

    // Sweep driver with a position (0..7..0) and interval (tick every 10 cycles) model.
    task automatic run_sweep(input bit stuck, input int reset_step,
                             output int steps, output int acc, output bit timeout);
        int pos = 0;
        int cnt = 0;
        bit up = 1'b1;
        bit started = 1'b0;
        logic p_zu, p_cu, p_zi, p_ci;
        steps = 0; acc = 0; timeout = 1'b1;
        drive(1, 0, 1, 0, stuck ? 1'b0 : 1'b1);
        for (int c = 0; c < 600; c++) begin
            {p_zu, p_cu, p_zi, p_ci} = {zeraUpdown, contaUpdown, zeraIntervalo, contaIntervalo};
            tick();
            if (p_zu) begin
                pos = 0; up = 1'b1;
            end else if (p_cu) begin
                if (up) begin pos++; if (pos == 7) up = 1'b0; end
                else    begin pos--; if (pos == 0) up = 1'b1; end
            end
            if (p_zi) cnt = 0;
            else if (p_ci) cnt = (cnt == 9) ? 0 : cnt + 1;
            comando = 1'b0;
            inicioPosicao = stuck ? 1'b0 : (pos == 0);
            fimContadorIntervalo = (cnt == 9);
            fimPosicao = (pos == 7) || (pos == 0);
            if (contaUpdown) steps++;
            if (aceito) acc++;
            if (db_estado != 4'd1) started = 1'b1;
            if (reset_step != 0 && steps == reset_step && db_estado == 4'd6) begin
                reset = 1'b1; timeout = 1'b0; break;
            end
            if ((started && db_estado == 4'd1) || db_estado == 4'd9) begin
                timeout = 1'b0; break;
            end
        end
    endtask

    initial begin
        int steps, acc, avalias, pronto_at;
        bit to;

        vecs[0]  = '{0, 0, 0, 0, 0, 4'd1, O_ESP};
        vecs[1]  = '{1, 0, 0, 0, 0, 4'd2, O_NON};
        vecs[2]  = '{1, 0, 0, 0, 0, 4'd3, O_REJ};
        vecs[3]  = '{1, 0, 0, 0, 0, 4'd1, O_ESP};
        vecs[4]  = '{1, 0, 0, 0, 0, 4'd1, O_ESP};
        vecs[5]  = '{0, 0, 0, 0, 0, 4'd1, O_ESP};
        vecs[6]  = '{1, 1, 1, 0, 0, 4'd2, O_NON};
        vecs[7]  = '{1, 1, 1, 0, 0, 4'd4, O_NCF};
        vecs[8]  = '{0, 0, 1, 0, 0, 4'd1, O_ESP};
        vecs[9]  = '{1, 0, 1, 0, 0, 4'd2, O_NON};
        vecs[10] = '{1, 0, 1, 0, 0, 4'd5, O_PAS};
        vecs[11] = '{1, 0, 0, 0, 0, 4'd6, O_AGU};
        vecs[12] = '{0, 0, 0, 0, 0, 4'd6, O_AGU};
        vecs[13] = '{1, 0, 0, 1, 0, 4'd7, O_NON};
        vecs[14] = '{0, 0, 0, 0, 1, 4'd8, O_FIM};
        vecs[15] = '{0, 0, 0, 0, 0, 4'd1, O_ESP};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].cmd, vecs[i].pmz, vecs[i].pert, vecs[i].fim, vecs[i].ini);
            tick();
            check($sformatf("vec%0d_estado", i), 32'(db_estado), 32'(vecs[i].est));
            check($sformatf("vec%0d_saidas", i), 32'(act_out), 32'(vecs[i].out));
        end

        // comando held high for 20 cycles: one evaluation, pronto back 3 cycles after the edge.
        do_reset();
        tick();
        avalias = 0; pronto_at = -1;
        drive(1, 0, 0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (db_estado == 4'd2) avalias++;
            if (pronto_at < 0 && c > 1 && pronto) pronto_at = c;
        end
        check("held_cmd_avalia_count", 32'(avalias), 32'd1);
        check("held_cmd_pronto_latency", 32'(pronto_at), 32'd3);
        drive(0, 0, 0, 0, 0);
        tick();

        // Full accepted sweep.
        run_sweep(1'b0, 0, steps, acc, to);
        check("sweep_timeout", 32'(to), 32'd0);
        check("sweep_steps", 32'(steps), 32'd14);
        check("sweep_aceito", 32'(acc), 32'd1);
        check("sweep_end_estado", 32'(db_estado), 32'd1);

        // Second sweep succeeds too, so the step count restarted from zero.
        tick();
        run_sweep(1'b0, 0, steps, acc, to);
        check("sweep2_steps", 32'(steps), 32'd14);
        check("sweep2_aceito", 32'(acc), 32'd1);

        // Gate never returns: watchdog after 14 steps, sticky until reset.
        tick();
        run_sweep(1'b1, 0, steps, acc, to);
        check("wd_timeout", 32'(to), 32'd0);
        check("wd_steps", 32'(steps), 32'd14);
        check("wd_estado", 32'(db_estado), 32'd9);
        check("wd_saidas", 32'(act_out), 32'(O_ERR));
        for (int c = 0; c < 10; c++) begin
            comando = c[0];
            tick();
        end
        check("wd_sticky_estado", 32'(db_estado), 32'd9);
        check("wd_sticky_erro", 32'(erro), 32'd1);
        do_reset();
        check("wd_cleared_erro", 32'(erro), 32'd0);

        // Reset while waiting on the interval at step 5.
        tick();
        run_sweep(1'b0, 5, steps, acc, to);
        check("midreset_found", 32'(to), 32'd0);
        check("midreset_steps", 32'(steps), 32'd5);
        tick();
        check("midreset_estado", 32'(db_estado), 32'd0);
        check("midreset_saidas", 32'(act_out), 32'(O_INI));
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        check("midreset_espera", 32'(db_estado), 32'd1);
        check("midreset_no_aceito", 32'(acc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
